// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - serial byte-stream loader that fills instruction memory and releases cpu reset
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (trailing XOR checksum byte and CHECK state)
module imem_boot_loader #(
   parameter int         ADDR_W    = 6,
   parameter int         DEPTH     = 64,
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [2:0] S_SYNC   = 3'd0;
   localparam logic [2:0] S_COUNT  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   // 9-bit copy of DEPTH so a count of up to 255 can be compared without truncation
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   logic [2:0]        state;
   logic [2:0]        state_nx;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W-1:0] word_last;
   logic [1:0]        byte_idx;
   logic [23:0]       asm_q;
   logic              count_bad;
   logic              last_byte;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign count_bad = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH_W);
   assign last_byte = (byte_idx == 2'd3) && (word_idx == word_last);

   // Next-state selection; a sync byte seen after SYNC is plain payload
   always_comb begin
      state_nx = state;
      case (state)
         S_SYNC:   if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_COUNT;
         S_COUNT:  if (rx_valid) state_nx = count_bad ? S_ERR : S_DATA;
         S_DATA: begin
            if (rx_valid && last_byte) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
               state_nx = S_CHECK;
`else
               state_nx = S_FINISH;
`endif
            end
         end
         S_CHECK: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            if (rx_valid) state_nx = (rx_data == csum) ? S_FINISH : S_ERR;
`else
            state_nx = S_ERR;
`endif
         end
         S_FINISH: state_nx = S_DONE;
         default:  state_nx = state;
      endcase
   end

   // State, registered status flags and word assembly / memory write datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_SYNC;
         word_idx  <= '0;
         word_last <= '0;
         byte_idx  <= 2'd0;
         asm_q     <= 24'd0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wd    <= 32'd0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         state     <= state_nx;
         busy      <= (state_nx == S_COUNT) || (state_nx == S_DATA) ||
                      (state_nx == S_CHECK) || (state_nx == S_FINISH);
         done      <= (state_nx == S_DONE);
         error     <= (state_nx == S_ERR);
         cpu_reset <= (state_nx != S_DONE);
         mem_we    <= 1'b0;
         if (state == S_COUNT && rx_valid) begin
            word_last <= ADDR_W'(rx_data - 8'd1);
            word_idx  <= '0;
            byte_idx  <= 2'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum      <= 8'd0;
`endif
         end
         if (state == S_DATA && rx_valid) begin
            asm_q    <= {asm_q[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            if (byte_idx == 2'd3) begin
               mem_we   <= 1'b1;
               mem_addr <= word_idx;
               mem_wd   <= {asm_q, rx_data};
               word_idx <= word_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Serial program loader sitting directly upstream of the instruction memory in the single-cycle MIPS system.
- Accepts a byte stream, for example from a UART receiver, and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a synchronous write port.
- Holds the processor in reset until a complete, valid image has been loaded.

Parameters:
- ADDR_W, 6, word-address width of instruction memory.
- DEPTH, 64, maximum words loadable; must equal 2**ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wd  out  32  write data.
- cpu_reset  out  1  processor reset, held high until load is complete.
- busy  out  1  frame in progress (state not SYNC/DONE/ERR).
- done  out  1  image loaded successfully; sticky.
- error  out  1  frame rejected; sticky.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: mem_we=0, mem_addr=0, mem_wd=0, cpu_reset=1, busy=0, done=0, error=0. Internal state is SYNC and all counters are 0.
- A byte is "accepted" at a rising edge where rx_valid=1. Bytes may arrive on consecutive cycles; no back-pressure exists.
- Frame format: SYNC_BYTE, count N (8 bits), then 4*N data bytes with the MSB of each word first, then one checksum byte (CHECKSUM_EN only).
- SYNC state: bytes other than SYNC_BYTE are ignored. On SYNC_BYTE, go to COUNT.
- COUNT state:
  - N=0 or N>DEPTH goes to ERR.
  - Otherwise latch N, clear the word index and byte index to 0, and go to DATA.
- DATA state:
  - Shift each byte into a 32-bit assembly register.
  - On the 4th byte of a word: at that same edge, set mem_wd = assembled word, mem_addr = word index, and mem_we=1 for exactly one cycle. Then increment the word index.
  - The byte index wraps 3 to 0.
  - After word N-1: go to CHECK (CHECKSUM_EN) or FINISH.
- CHECK state: the next accepted byte is compared with the running XOR of all 4*N data bytes. A match goes to FINISH; a mismatch goes to ERR.
- FINISH state: lasts one cycle, guaranteeing the final write has completed. Then go to DONE.
- Entering DONE (the edge after FINISH): done=1, cpu_reset=0, busy=0.
- DONE state: all further bytes are ignored; only reset leaves it.
- ERR state:
  - error=1, busy=0, cpu_reset stays 1, mem_we=0. Bytes are ignored.
  - Words already written are not undone.
  - Only reset leaves it.
- mem_we is never high in SYNC, COUNT, CHECK, DONE or ERR.
- mem_addr and mem_wd hold their last values between pulses.
- Reset mid-frame (any state): return to SYNC with the reset values above on the next edge. Memory contents are untouched. A subsequent full frame must load correctly.
- A SYNC_BYTE value occurring inside the count, data or checksum is treated as data. No resynchronisation occurs mid-frame.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined: the frame carries a trailing XOR checksum byte, and the CHECK state is implemented as above.
- Undefined:
  - No checksum byte is expected and the XOR accumulator is absent.
  - After the last data word, go directly to FINISH.
  - A byte arriving in DONE is ignored.

Test Plan:
- Load words 32'h20080005 and 32'hAC080000 with N=2 and checksum 8'h89 (XOR of 20,08,00,05,AC,08,00,00):
  - mem_we pulses twice, at addr 0 then addr 1, with exact data.
  - done=1 and cpu_reset=0 two cycles after the checksum byte.
- Same frame with bytes on every consecutive cycle, versus 3 idle cycles between bytes: identical writes and final state.
- Leading bytes 8'h00, 8'hFF, 8'h5A before SYNC_BYTE: ignored, then the frame loads correctly. Also N=64 fills addresses 0..63 and done asserts.
- N=0: error=1, no mem_we. After reset, N=65: error=1, no mem_we. cpu_reset=1 throughout.
- Valid N=1 frame with checksum 8'h00 when 8'h2D is expected:
  - One mem_we pulse at addr 0, then error=1.
  - done=0 and cpu_reset=1.
- Reset asserted after 5 bytes of an N=2 frame: busy=0, mem_we=0 on the next edge, state back in SYNC. A full frame then completes with done=1.
